// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants, FSM state type and LFSR step function for the PRBS burst generator
package prbs_pkg;
    localparam int PRBS_W = 128;
    localparam logic [PRBS_W-1:0] PRBS_SEED_DFLT = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam int TAP0 = 127;
    localparam int TAP1 = 125;
    localparam int TAP2 = 100;
    localparam int TAP3 = 98;

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} prbs_state_t;

    function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] s, input int n);
        logic [PRBS_W-1:0] r;
        r = s;
        for (int i = 0; i < PRBS_W; i++)
            if (i < n) r = {r[PRBS_W-2:0], r[TAP0] ^ r[TAP1] ^ r[TAP2] ^ r[TAP3]};
        return r;
    endfunction
endpackage

// File: rtl/prbs_fifo.sv
// prbs_fifo: first-word-fall-through sync FIFO; a push is refused while full even if a pop coincides
module prbs_fifo
    import prbs_pkg::*;
#(
    parameter int W     = PRBS_W + 1,
    parameter int DEPTH = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    // pointer and occupancy bookkeeping
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // storage array, written on accepted pushes only
    always_ff @(posedge ck) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/prbs_burst_gen.sv
// prbs_burst_gen: burst PRBS word generator with elastic output FIFO (optional PRBS_ERR_INJ_EN error injection)
module prbs_burst_gen
    import prbs_pkg::*;
#(
    parameter int SHIFTS = 1,
    parameter int DEPTH  = 4,
    parameter int CW     = 16
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              i_seed_ld,
    input  logic [PRBS_W-1:0] i_seed,
    input  logic              i_req,
    input  logic [CW-1:0]     i_cnt,
    output logic              o_busy,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [63:0]       o_res_lower,
    output logic [63:0]       o_res_upper,
    output logic              o_last
`ifdef PRBS_ERR_INJ_EN
    ,
    input  logic              i_err_inj
`endif
);
    prbs_state_t       state, state_n;
    logic [CW-1:0]     rem, rem_n;
    logic [PRBS_W-1:0] lfsr, lfsr_n;
    logic              push, pop, full, empty, inj;
    logic [PRBS_W:0]   head;

    assign pop         = o_vld & i_rdy;
    assign o_vld       = ~empty;
    assign o_last      = o_vld & head[PRBS_W];
    assign o_res_lower = head[63:0];
    assign o_res_upper = head[127:64];
    assign o_busy      = state != IDLE;

    // next-state, LFSR advance and push decision
    always_comb begin
        state_n = state;
        rem_n   = rem;
        lfsr_n  = lfsr;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (i_seed_ld) lfsr_n = (i_seed == '0) ? PRBS_SEED_DFLT : i_seed;
                if (i_req && i_cnt != '0) begin
                    state_n = GEN;
                    rem_n   = i_cnt;
                end
            end
            GEN: begin
                if (!full) begin
                    push    = 1'b1;
                    lfsr_n  = prbs_step(lfsr, SHIFTS);
                    rem_n   = rem - 1'b1;
                    state_n = (rem == CW'(1)) ? DRAIN : GEN;
                end
            end
            DRAIN: state_n = (empty || (pop && head[PRBS_W])) ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // FSM, remaining count and LFSR registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            lfsr  <= PRBS_SEED_DFLT;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            lfsr  <= lfsr_n;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    // one-shot flag: armed by a pulse, consumed by the next push; only the FIFO copy is corrupted
    always_ff @(posedge ck or posedge rst) begin
        if (rst) inj <= 1'b0;
        else inj <= (inj & ~push) | i_err_inj;
    end
`else
    assign inj = 1'b0;
`endif

    prbs_fifo #(.W(PRBS_W + 1), .DEPTH(DEPTH)) u_fifo (
        .ck   (ck),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  ({rem == CW'(1), lfsr ^ {{(PRBS_W-1){1'b0}}, inj}}),
        .dout (head),
        .full (full),
        .empty(empty)
    );
endmodule

// File: tb/tb_prbs_burst_gen.sv
// tb_prbs_burst_gen: directed self-checking bench for prbs_burst_gen (covers PRBS_ERR_INJ_EN when defined)
module tb_prbs_burst_gen;
    localparam int CW = 16;
    localparam logic [127:0] DFLT = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          i_seed_ld = 1'b0, i_req = 1'b0, i_rdy = 1'b0, i_err_inj = 1'b0;
    logic [127:0]  i_seed = '0;
    logic [CW-1:0] i_cnt = '0;
    logic          o_busy, o_vld, o_last;
    logic [63:0]   o_res_lower, o_res_upper;

    int           compared = 0, mismatched = 0;
    bit           rnd_rdy = 0;
    logic [127:0] mdl;
    logic [128:0] q[$];

    always #5 ck = ~ck;

    prbs_burst_gen #(.SHIFTS(1), .DEPTH(4), .CW(CW)) dut (
        .ck         (ck),
        .rst        (rst),
        .i_seed_ld  (i_seed_ld),
        .i_seed     (i_seed),
        .i_req      (i_req),
        .i_cnt      (i_cnt),
        .o_busy     (o_busy),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_res_lower(o_res_lower),
        .o_res_upper(o_res_upper),
        .o_last     (o_last)
`ifdef PRBS_ERR_INJ_EN
        ,
        .i_err_inj  (i_err_inj)
`endif
    );

    // record every word that will be handshaken at the next rising edge
    always @(negedge ck)
        if (!rst && o_vld && i_rdy) q.push_back({o_last, o_res_upper, o_res_lower});

    function automatic logic [127:0] step_m(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
        if (rnd_rdy) i_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic start(input int n);
        i_req = 1'b1;
        i_cnt = CW'(n);
        tick();
        i_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && o_busy; i++) tick();
        compared++;
        if (o_busy) begin
            mismatched++;
            $display("FAIL wait_idle: o_busy=%0b still set, want 0", o_busy);
        end
    endtask

    task automatic check_q(input string name, input int n, input int last_a, input int last_b);
        compared++;
        if (q.size() != n) begin
            mismatched++;
            $display("FAIL %s_count: got %0d words want %0d", name, q.size(), n);
        end
        for (int i = 0; i < n && i < q.size(); i++) begin
            compared++;
            if (q[i] !== {1'(i == last_a || i == last_b), mdl}) begin
                mismatched++;
                $display("FAIL %s_word%0d: got %h want %h", name, i, q[i], {1'(i == last_a || i == last_b), mdl});
            end
            mdl = step_m(mdl);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        compared++;
        if ({o_vld, o_busy, o_last} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_outputs: got vld/busy/last=%b want 000", {o_vld, o_busy, o_last});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        i_rdy = 1'b1;
        start(2);
        compared++;
        if (o_vld !== 1'b0 || o_busy !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_latency: got vld=%b busy=%b want vld=0 busy=1", o_vld, o_busy);
        end
        tick();
        compared++;
        if ({o_vld, o_last, o_res_upper, o_res_lower} !== {2'b10, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210}) begin
            mismatched++;
            $display("FAIL basic_word0: got vld=%b last=%b %h_%h want 1 0 0123456789abcdef_fedcba9876543210", o_vld, o_last, o_res_upper, o_res_lower);
        end
        tick();
        compared++;
        if ({o_vld, o_last, o_res_upper, o_res_lower} !== {2'b11, 64'h02468ACF13579BDF, 64'hFDB97530ECA86421}) begin
            mismatched++;
            $display("FAIL basic_word1: got vld=%b last=%b %h_%h want 1 1 02468acf13579bdf_fdb97530eca86421", o_vld, o_last, o_res_upper, o_res_lower);
        end
        tick();
        compared++;
        if (o_vld !== 1'b0 || o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_end: got vld=%b busy=%b want 0 0", o_vld, o_busy);
        end
        q.delete();
    endtask

    task automatic test_seed();
        i_seed_ld = 1'b1;
        i_seed = '0;
        tick();
        i_seed_ld = 1'b0;
        start(1);
        wait_idle();
        mdl = DFLT;
        check_q("seed_zero", 1, 0, 0);
        q.delete();
        i_seed_ld = 1'b1;
        i_seed = 128'h1;
        start(1);
        i_seed_ld = 1'b0;
        wait_idle();
        mdl = 128'h1;
        check_q("seed_one", 1, 0, 0);
        q.delete();
    endtask

    task automatic test_stall();
        i_rdy = 1'b0;
        start(10);
        repeat (20) tick();
        compared++;
        if (dut.u_fifo.cnt !== 3'd4 || o_busy !== 1'b1 || o_vld !== 1'b1 || q.size() != 0) begin
            mismatched++;
            $display("FAIL stall_fill: got cnt=%0d busy=%b vld=%b popped=%0d want 4 1 1 0", dut.u_fifo.cnt, o_busy, o_vld, q.size());
        end
        i_rdy = 1'b1;
        wait_idle();
        check_q("stall", 10, 9, 9);
        q.delete();
    endtask

    task automatic test_back_to_back();
        rnd_rdy = 1;
        start(7);
        repeat (3) tick();
        i_req = 1'b1;
        i_cnt = CW'(3);
        tick();
        i_req = 1'b0;
        wait_idle();
        start(5);
        wait_idle();
        rnd_rdy = 0;
        i_rdy = 1'b1;
        check_q("b2b", 12, 6, 11);
        q.delete();
    endtask

    task automatic test_reset_mid();
        i_rdy = 1'b1;
        start(8);
        for (int i = 0; i < 50 && q.size() < 3; i++) tick();
        rst = 1'b1;
        #1;
        compared++;
        if (o_vld !== 1'b0 || o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: got vld=%b busy=%b want 0 0", o_vld, o_busy);
        end
        tick();
        rst = 1'b0;
        q.delete();
        tick();
        start(1);
        wait_idle();
        mdl = DFLT;
        check_q("reset_restart", 1, 0, 0);
        q.delete();
    endtask

`ifdef PRBS_ERR_INJ_EN
    task automatic test_err_inj();
        logic [127:0] m;
        i_rdy = 1'b1;
        start(4);
        tick();
        i_err_inj = 1'b1;
        tick();
        i_err_inj = 1'b0;
        wait_idle();
        compared++;
        if (q.size() != 4) begin
            mismatched++;
            $display("FAIL inj_count: got %0d want 4", q.size());
        end
        m = mdl;
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            compared++;
            if (q[i] !== {1'(i == 3), m ^ 128'(i == 2)}) begin
                mismatched++;
                $display("FAIL inj_word%0d: got %h want %h", i, q[i], {1'(i == 3), m ^ 128'(i == 2)});
            end
            m = step_m(m);
        end
        mdl = m;
        q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_seed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef PRBS_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/prbs_burst_gen.md
# prbs_burst_gen

Parametrised successor to the single-step 128-bit PRBS source used by the user-IO vadd test personalities. It generates bursts of 128-bit pseudo-random words from the same polynomial (x^128 + x^126 + x^101 + x^99, Fibonacci, shift-left). Each word advances the LFSR by a configurable number of steps. Words pass through an elastic output FIFO under valid/ready backpressure, and the seed is run-time loadable. It sits between the personality control logic and the vadd data path as the stimulus/reference source.

## Interface
Parameters:
- SHIFTS, 1: LFSR steps per generated word, 1..128, unrolled combinationally.
- DEPTH, 4: output FIFO depth, power of 2, ≥2.
- CW, 16: width of burst word count.

Ports:
- ck  in  1  clock.
- rst  in  1  reset; asynchronous assert, active-high.
- i_seed_ld  in  1  load i_seed into LFSR; honoured only in IDLE.
- i_seed  in  128  seed value.
- i_req  in  1  burst request; accepted only when o_busy=0.
- i_cnt  in  CW  words in burst, sampled with i_req; 0 = request ignored.
- o_busy  out  1  burst in progress (GEN or DRAIN).
- o_vld  out  1  FIFO head word valid.
- i_rdy  in  1  consumer accepts head word when o_vld & i_rdy.
- o_res_lower  out  64  head word bits [63:0].
- o_res_upper  out  64  head word bits [127:64].
- o_last  out  1  head word is final word of burst.
- i_err_inj  in  1  error-injection pulse; present only with PRBS_ERR_INJ_EN.

## Operation
- Reset values: LFSR = 128'h0123456789ABCDEFFEDCBA9876543210, FSM = IDLE, FIFO empty, remaining count = 0, o_busy=0, o_vld=0, o_last=0. o_res_* are don't-care while o_vld=0.
- Step function: next = {s[126:0], s[127]^s[125]^s[100]^s[98]}. It is applied SHIFTS times per generated word.
- FSM states:
  - IDLE: i_req & i_cnt≠0 → GEN, with remaining = i_cnt.
  - GEN: each cycle the FIFO is not full, push the current LFSR state as a word, advance the LFSR by SHIFTS, and decrement remaining. The push with remaining=1 carries last=1 and moves to DRAIN. The state is unchanged in a cycle where the FIFO is full (stall, no advance).
  - DRAIN: when the FIFO becomes empty (last word popped) → IDLE.
- Words are pushed in generation order. None are dropped, duplicated or reordered under any i_rdy pattern.
- Seed load: in IDLE, i_seed_ld loads i_seed. An all-zero i_seed loads the reset seed instead (lock-up avoidance). i_seed_ld in GEN/DRAIN is ignored.
- i_seed_ld and i_req in the same IDLE cycle: the seed is loaded, and the first burst word equals the loaded seed.
- i_req while o_busy=1 is ignored, with no queuing.
- The LFSR state persists across bursts; consecutive bursts continue the sequence.
- Reset mid-burst: all state returns to reset values immediately (asynchronous), and FIFO contents are discarded.

## Timing
- Request accepted at edge N (IDLE, i_req=1). The first push is at edge N+1. o_vld=1 from after edge N+1, giving 2-cycle request-to-data latency, matching the prior generator.
- FIFO is first-word-fall-through. o_res_*, o_vld and o_last are driven from registered FIFO storage, with no combinational path from i_rdy to outputs.
- With i_rdy=1 continuously: one word per cycle, and a burst of K words occupies o_vld for K consecutive cycles.
- A push and a pop in the same cycle when the FIFO is full are not allowed. Full blocks the push regardless of the pop, so there is one bubble per full-stall (accepted simplicity).
- o_busy falls the cycle after the handshake of the o_last word.

## Configuration
- PRBS_ERR_INJ_EN defined:
  - Port i_err_inj exists.
  - A pulse arms a one-shot flag. The next pushed word has bit 0 inverted in the FIFO copy only; the LFSR sequence is unaffected.
  - The flag clears on that push, and pulses while the flag is armed merge.
  - The flag is reset to 0.
- PRBS_ERR_INJ_EN undefined: the port is absent and words are always the exact LFSR state.

## Structure
- Package prbs_pkg:
  - PRBS_W=128.
  - PRBS_SEED_DFLT.
  - Tap index constants (127,125,100,98).
  - Function prbs_step(state, n) returning the state advanced n steps.
- Sub-module prbs_fifo:
  - Parametrised FWFT sync FIFO, width 129 (word + last), depth DEPTH.
  - Async active-high reset on pointers/count.
  - Flags: full and empty.
- Top: FSM, remaining counter, LFSR register, optional injection flag.

## Test plan
- Reset, SHIFTS=1, i_req with i_cnt=2, i_rdy=1 → word0 upper=0123456789ABCDEF, lower=FEDCBA9876543210. word1 upper=02468ACF13579BDF, lower=FDB97530ECA86421 with o_last=1. o_vld first high 2 cycles after request.
- Load i_seed=0 in IDLE, then burst of 1 → word equals default seed. Load 128'h1, burst of 1 → word = 128'h1.
- DEPTH=4, burst i_cnt=10, i_rdy held low 20 cycles then high → exactly 4 pushes during stall, o_busy=1, then 10 words, matching a reference model, o_last only on the 10th.
- Random i_rdy (50%), two back-to-back bursts of 7 and 5 → 12 words forming a continuous model sequence. i_req during the first burst is ignored.
- Assert rst mid-burst (after 3 of 8 words) → o_vld=0 and o_busy=0 immediately. A new burst restarts from the default seed.
- PRBS_ERR_INJ_EN: pulse i_err_inj before word 2 of a 4-word burst → only word 2 has lower[0] inverted, and word 3 matches the model.
